// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI frame sequencer.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    WAIT,
    HOLD
  } ctrl_state_t;

  typedef logic [7:0] byte_t;

  localparam byte_t SPI_CMD_DEFAULT = 8'hA5;

endpackage

// File: rtl/spi_send_ctrl_if.sv
// Byte handshake between the frame sequencer (master side) and the SPI byte engine.
interface spi_send_ctrl_if;
  import spi_pkg::*;

  byte_t tx_data;
  logic  tx_valid;
  logic  tx_ready;
  logic  tx_done;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx_done
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx_done
  );

endinterface

// File: rtl/spi_gap_timer.sv
// 8-bit loadable down-counter; expired is high in the cycle whose edge takes it to 0,
// so a consumer registering on expired acts exactly 'value' edges after the load.
module spi_gap_timer (
  input  logic       clk_100,
  input  logic       a_rst_n,
  input  logic       s_rst,
  input  logic       load,
  input  logic [7:0] value,
  output logic       expired
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk_100 or negedge a_rst_n) begin
    if (!a_rst_n) begin
      cnt_q <= 8'd0;
    end else if (s_rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == 8'd1);

endmodule

// File: rtl/spi_send_ctrl.sv
// Frame sequencer: free-running count, snapshot on request, chip-select framed burst
// of a command byte followed by the snapshot (MSB byte first), one request queued.
module spi_send_ctrl
  import spi_pkg::*;
#(
  parameter int    CNT_W    = 16,
  parameter byte_t CMD_BYTE = SPI_CMD_DEFAULT,
  parameter int    CS_SETUP = 4,
  parameter int    CS_HOLD  = 4
) (
  input  logic              clk_100,
  input  logic              a_rst_n,
  input  logic              s_rst,
  input  logic              next_count,
  input  logic              start_send,
  spi_send_ctrl_if.master   tx,
  output logic              cs_n,
  output logic              busy,
  output logic              frame_done,
  output logic [CNT_W-1:0]  count
);

  localparam int NB    = 1 + CNT_W / 8;
  localparam int IDX_W = $clog2(NB + 1);

  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             pend_q, pend_d;
  logic             cs_n_q, cs_n_d;
  logic             tx_valid_q, tx_valid_d;
  byte_t            tx_data_q, tx_data_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;

  logic             tmr_load;
  logic [7:0]       tmr_value;
  logic             tmr_expired;

  spi_gap_timer u_gap_timer (
    .clk_100 (clk_100),
    .a_rst_n (a_rst_n),
    .s_rst   (s_rst),
    .load    (tmr_load),
    .value   (tmr_value),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    shift_d      = shift_q;
    idx_d        = idx_q;
    pend_d       = pend_q;
    cs_n_d       = cs_n_q;
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    tmr_load     = 1'b0;
    tmr_value    = 8'd0;

    if (next_count) begin
      count_d = count_q + 1'b1;
    end

    // Only one request is remembered while a frame is in flight; extras are dropped.
    if (start_send && (state_q != IDLE)) begin
      pend_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start_send || pend_q) begin
          shift_d   = count_q;
          idx_d     = '0;
          pend_d    = 1'b0;
          cs_n_d    = 1'b0;
          busy_d    = 1'b1;
          tmr_load  = 1'b1;
          tmr_value = 8'(CS_SETUP);
          state_d   = SETUP;
        end
      end
      SETUP: begin
        if (tmr_expired) begin
          tx_valid_d = 1'b1;
          tx_data_d  = CMD_BYTE;
          state_d    = XFER;
        end
      end
      XFER: begin
        if (tx.tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (tx.tx_done) begin
          idx_d = idx_q + 1'b1;
          if (idx_q != IDX_W'(NB - 1)) begin
            tx_valid_d = 1'b1;
            tx_data_d  = shift_q[CNT_W-1 -: 8];
            shift_d    = shift_q << 8;
            state_d    = XFER;
          end else begin
            tmr_load  = 1'b1;
            tmr_value = 8'(CS_HOLD);
            state_d   = HOLD;
          end
        end
      end
      HOLD: begin
        if (tmr_expired) begin
          cs_n_d       = 1'b1;
          busy_d       = 1'b0;
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_100 or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      shift_q      <= '0;
      idx_q        <= '0;
      pend_q       <= 1'b0;
      cs_n_q       <= 1'b1;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= 8'd0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else if (s_rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      shift_q      <= '0;
      idx_q        <= '0;
      pend_q       <= 1'b0;
      cs_n_q       <= 1'b1;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= 8'd0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      shift_q      <= shift_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      cs_n_q       <= cs_n_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;
  assign cs_n        = cs_n_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign count       = count_q;

endmodule

// File: tb/tb_spi_send_ctrl.sv
// Scoreboard bench for spi_send_ctrl: requests push expected frame bytes, a monitor
// pops them at each byte handshake and checks chip-select gaps and frame_done.
module tb_spi_send_ctrl;
  import spi_pkg::*;

  localparam int    CNT_W    = 16;
  localparam int    CS_SETUP = 4;
  localparam int    CS_HOLD  = 4;
  localparam byte_t CMD      = 8'hA5;

  logic             clk_100    = 1'b0;
  logic             a_rst_n    = 1'b0;
  logic             s_rst      = 1'b0;
  logic             next_count = 1'b0;
  logic             start_send = 1'b0;
  logic             cs_n;
  logic             busy;
  logic             frame_done;
  logic [CNT_W-1:0] count;

  spi_send_ctrl_if tx ();

  spi_send_ctrl #(
    .CNT_W    (CNT_W),
    .CMD_BYTE (CMD),
    .CS_SETUP (CS_SETUP),
    .CS_HOLD  (CS_HOLD)
  ) dut (
    .clk_100    (clk_100),
    .a_rst_n    (a_rst_n),
    .s_rst      (s_rst),
    .next_count (next_count),
    .start_send (start_send),
    .tx         (tx),
    .cs_n       (cs_n),
    .busy       (busy),
    .frame_done (frame_done),
    .count      (count)
  );

  always #5 clk_100 = ~clk_100;

  int cyc = 0;
  always @(posedge clk_100) cyc <= cyc + 1;

  int               errors = 0;
  int               checks = 0;
  byte_t            exp_q[$];
  int               accepted = 0;
  int               done_cnt = 0;
  int               pops = 0;
  int               last_done_edge = 0;
  logic [CNT_W-1:0] model_count = '0;
  bit               abort_flag = 1'b0;
  bit               bp_request = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Model SPI master: immediate ready (or 20 cycles of back-pressure), done 8 cycles later.
  initial begin
    int    done_timer = 0;
    int    bp_left = 0;
    byte_t held = 8'd0;
    tx.tx_ready = 1'b0;
    tx.tx_done  = 1'b0;
    forever begin
      @(negedge clk_100);
      tx.tx_ready = 1'b0;
      tx.tx_done  = 1'b0;
      if (!a_rst_n || s_rst) begin
        done_timer = 0;
        bp_left    = 0;
      end else if (done_timer > 0) begin
        done_timer--;
        if (done_timer == 0) begin
          tx.tx_done     = 1'b1;
          last_done_edge = cyc + 1;
        end
      end else if (bp_left > 0) begin
        check("bp_valid_held", {31'd0, tx.tx_valid}, 32'd1);
        check("bp_data_held", {24'd0, tx.tx_data}, {24'd0, held});
        if (bp_left == 10) tx.tx_done = 1'b1;
        bp_left--;
      end else if (tx.tx_valid) begin
        if (bp_request) begin
          bp_request = 1'b0;
          bp_left    = 19;
          held       = tx.tx_data;
        end else begin
          tx.tx_ready = 1'b1;
          done_timer  = 8;
        end
      end
    end
  end

  // Monitor: byte scoreboard plus chip-select framing checks.
  initial begin
    logic prev_cs = 1'b1;
    logic prev_fd = 1'b0;
    int   fall_edge = 0;
    int   rise_edge = -10;
    bit   want_first = 1'b0;
    forever begin
      @(negedge clk_100);
      #2;
      if (tx.tx_valid && tx.tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %02h required none", tx.tx_data);
        end else begin
          check("tx_byte", {24'd0, tx.tx_data}, {24'd0, exp_q.pop_front()});
          pops++;
        end
      end
      if (prev_cs && !cs_n) begin
        fall_edge  = cyc;
        want_first = 1'b1;
        check("busy_at_cs_fall", {31'd0, busy}, 32'd1);
        check("cs_high_gap", {31'd0, (cyc - rise_edge) >= 1}, 32'd1);
      end
      if (want_first && tx.tx_valid) begin
        want_first = 1'b0;
        check("setup_gap", cyc - fall_edge, CS_SETUP);
      end
      if (!prev_cs && cs_n) begin
        rise_edge = cyc;
        if (abort_flag) begin
          abort_flag = 1'b0;
          check("no_fd_on_abort", {31'd0, frame_done}, 32'd0);
        end else begin
          check("hold_gap", cyc - last_done_edge, CS_HOLD);
          check("fd_at_cs_rise", {31'd0, frame_done}, 32'd1);
          check("busy_clear", {31'd0, busy}, 32'd0);
        end
      end
      if (frame_done) begin
        check("fd_single_cycle", {31'd0, prev_fd}, 32'd0);
        done_cnt++;
      end
      prev_cs = cs_n;
      prev_fd = frame_done;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk_100);
  endtask

  task automatic pulse_count(input int n);
    for (int i = 0; i < n; i++) begin
      next_count  = 1'b1;
      model_count = model_count + 1'b1;
      tick();
    end
    next_count = 1'b0;
  endtask

  // Frames in flight: 0 -> starts now, 1 -> queued, 2 -> dropped.
  task automatic request(input bit with_inc);
    int outstanding;
    outstanding = accepted - done_cnt;
    if (outstanding < 2) begin
      accepted++;
      exp_q.push_back(CMD);
      for (int b = CNT_W / 8 - 1; b >= 0; b--) exp_q.push_back(byte_t'(model_count >> (8 * b)));
      $display("request: count=%04h outstanding=%0d -> accepted", model_count, outstanding);
    end else begin
      $display("request: count=%04h outstanding=%0d -> dropped", model_count, outstanding);
    end
    start_send = 1'b1;
    if (with_inc) next_count = 1'b1;
    tick();
    start_send = 1'b0;
    next_count = 1'b0;
    if (with_inc) model_count = model_count + 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while ((done_cnt != accepted) && (t < 3000)) begin
      tick();
      t++;
    end
    if (t >= 3000) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: frames done %0d required %0d", name, done_cnt, accepted);
    end
    tick(3);
  endtask

  task automatic chk_count(input string name);
    check(name, {16'd0, count}, {16'd0, model_count});
  endtask

  initial begin
    int base;
    int t;

    a_rst_n = 1'b0;
    tick(2);
    check("rst_count", {16'd0, count}, 32'd0);
    check("rst_cs_n", {31'd0, cs_n}, 32'd1);
    check("rst_tx_valid", {31'd0, tx.tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, tx.tx_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    a_rst_n = 1'b1;
    tick(2);

    pulse_count(3);
    request(1'b0);
    wait_idle("single");
    chk_count("count_after_single");

    pulse_count(2);
    request(1'b1);
    wait_idle("simultaneous");
    chk_count("count_after_simul");

    base = done_cnt;
    request(1'b0);
    tick(10);
    request(1'b0);
    tick(5);
    request(1'b0);
    wait_idle("queued");
    check("queued_frames", done_cnt - base, 2);

    bp_request = 1'b1;
    request(1'b0);
    wait_idle("backpressure");

    base = pops;
    request(1'b0);
    t = 0;
    while ((pops < base + 2) && (t < 500)) begin
      tick();
      t++;
    end
    if (t >= 500) begin
      checks++;
      errors++;
      $display("FAIL abort_wait_timeout: bytes %0d required %0d", pops - base, 2);
    end
    tick(3);
    abort_flag = 1'b1;
    exp_q.delete();
    accepted    = done_cnt;
    model_count = '0;
    a_rst_n     = 1'b0;
    #1;
    check("abort_cs_n", {31'd0, cs_n}, 32'd1);
    check("abort_tx_valid", {31'd0, tx.tx_valid}, 32'd0);
    check("abort_count", {16'd0, count}, 32'd0);
    tick(3);
    a_rst_n = 1'b1;
    tick(2);
    request(1'b0);
    wait_idle("after_abort");

    for (int r = 0; r < 4; r++) begin
      pulse_count($urandom_range(0, 40));
      bp_request = ($urandom_range(0, 1) == 1);
      request(1'b0);
      wait_idle("random");
      chk_count("count_random");
    end

    pulse_count(7);
    s_rst = 1'b1;
    tick();
    s_rst = 1'b0;
    model_count = '0;
    chk_count("count_after_s_rst");

    pulse_count(65535);
    chk_count("count_all_ones");
    pulse_count(1);
    chk_count("count_wrapped");
    request(1'b0);
    wait_idle("wrap");

    check("queue_empty", exp_q.size(), 0);
    check("frames_total", done_cnt, accepted);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
